// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//
// Execute stage of a five-stage MIPS-style pipeline plus the EX/MEM pipeline
// register that follows it. Operands are forwarded from the EX/MEM register
// (this block's own outputs) or from the MEM/WB write-back port. The ALU
// output, the store data, the destination register and the MEM/WB control
// bits are then registered.
//
// Parameters
//   FWD_EN        1 = forwarding muxes active; 0 = operands come straight
//                 from ReadData1_in / ReadData2_in
//
// Ports
//   clk, reset    rising-edge clock; synchronous active-high reset
//   ReadData1_in, ReadData2_in, sign_ext_in  ID/EX operands and immediate.
//                 sign_ext_in[5:0] also carries the R-type funct field.
//   Fw_rs_in, Fw_rt_in                       source register numbers
//   MUX_rd_in, MUX_rt_in                     destination candidates
//   RegDst_in, ALUSrc_in, MemtoReg_in, RegWrite_in, MemRead_in,
//   MemWrite_in, Branch_in, ALUop_in         ID/EX control
//   wb_RegWrite, wb_rd, wb_data              MEM/WB write-back, forwarded
//   stall         hold the EX/MEM register
//   flush         load a bubble: control bits and Zero cleared,
//                 data still loads
//   ALUResult_out, WriteData_out, WriteReg_out, Zero_out, Branch_out,
//   MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out
//                 registered EX/MEM outputs
// ---------------------------------------------------------------------------
module ex_mem_stage #(
   parameter logic FWD_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ReadData1_in,
   input  logic [31:0] ReadData2_in,
   input  logic [31:0] sign_ext_in,
   input  logic [4:0]  Fw_rs_in,
   input  logic [4:0]  Fw_rt_in,
   input  logic [4:0]  MUX_rd_in,
   input  logic [4:0]  MUX_rt_in,
   input  logic        RegDst_in,
   input  logic        ALUSrc_in,
   input  logic        MemtoReg_in,
   input  logic        RegWrite_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic        Branch_in,
   input  logic [1:0]  ALUop_in,
   input  logic        wb_RegWrite,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] ALUResult_out,
   output logic [31:0] WriteData_out,
   output logic [4:0]  WriteReg_out,
   output logic        Zero_out,
   output logic        Branch_out,
   output logic        MemtoReg_out,
   output logic        RegWrite_out,
   output logic        MemRead_out,
   output logic        MemWrite_out
);

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_t;

   logic [31:0] fwd_a;
   logic [31:0] fwd_b;
   logic [31:0] opnd_b;
   logic [31:0] alu_result;
   logic [4:0]  write_reg;
   alu_op_t     alu_op;

   // The EX/MEM match uses the registered outputs. During a stall those
   // outputs hold, so the older instruction still forwards correctly.
   // An EX/MEM match wins over MEM/WB because it is the younger producer.
   // Register 0 is never forwarded because it is hard-wired to zero.
   // NOTE: every signal assigned in an always_comb gets a default first.
   // Without that default, some path leaves the signal unassigned and
   // synthesis infers a latch.
   always_comb begin
      fwd_a = ReadData1_in;
      fwd_b = ReadData2_in;
      if (FWD_EN) begin
         if (RegWrite_out && (WriteReg_out != 5'd0) && (WriteReg_out == Fw_rs_in))
            fwd_a = ALUResult_out;
         else if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == Fw_rs_in))
            fwd_a = wb_data;

         if (RegWrite_out && (WriteReg_out != 5'd0) && (WriteReg_out == Fw_rt_in))
            fwd_b = ALUResult_out;
         else if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == Fw_rt_in))
            fwd_b = wb_data;
      end
   end

   assign opnd_b    = ALUSrc_in ? sign_ext_in : fwd_b;
   assign write_reg = RegDst_in ? MUX_rd_in : MUX_rt_in;

   // ALU control. For R-type instructions the funct field is the low six
   // bits of the sign-extended immediate. An unknown funct falls back to add.
   always_comb begin
      alu_op = ALU_ADD;
      case (ALUop_in)
         2'b01: alu_op = ALU_SUB;
         2'b10: begin
            case (sign_ext_in[5:0])
               6'b100000: alu_op = ALU_ADD;
               6'b100010: alu_op = ALU_SUB;
               6'b100100: alu_op = ALU_AND;
               6'b100101: alu_op = ALU_OR;
               6'b101010: alu_op = ALU_SLT;
               default:   alu_op = ALU_ADD;
            endcase
         end
         default: alu_op = ALU_ADD;
      endcase
   end

   // Add and sub wrap modulo 2^32. Overflow is ignored.
   always_comb begin
      alu_result = 32'd0;
      case (alu_op)
         ALU_ADD: alu_result = fwd_a + opnd_b;
         ALU_SUB: alu_result = fwd_a - opnd_b;
         ALU_AND: alu_result = fwd_a & opnd_b;
         ALU_OR:  alu_result = fwd_a | opnd_b;
         ALU_SLT: alu_result = {31'd0, ($signed(fwd_a) < $signed(opnd_b))};
         default: alu_result = fwd_a + opnd_b;
      endcase
   end

   // Data half of the EX/MEM register. A flush still loads this half, so
   // only the stall condition holds it.
   // NOTE: sequential state uses non-blocking (<=) assignments. Every flop
   // then samples its pre-edge value, and simulation matches the hardware
   // regardless of the order in which the processes run.
   always_ff @(posedge clk) begin
      if (reset) begin
         ALUResult_out <= 32'd0;
         WriteData_out <= 32'd0;
         WriteReg_out  <= 5'd0;
      end else if (flush || !stall) begin
         ALUResult_out <= alu_result;
         WriteData_out <= fwd_b;
         WriteReg_out  <= write_reg;
      end
   end

   // Control half of the EX/MEM register. A flush clears it and turns the
   // instruction into a bubble. Priority is reset > flush > stall > load.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         Zero_out     <= 1'b0;
         Branch_out   <= 1'b0;
         MemtoReg_out <= 1'b0;
         RegWrite_out <= 1'b0;
         MemRead_out  <= 1'b0;
         MemWrite_out <= 1'b0;
      end else if (!stall) begin
         Zero_out     <= (alu_result == 32'd0);
         Branch_out   <= Branch_in;
         MemtoReg_out <= MemtoReg_in;
         RegWrite_out <= RegWrite_in;
         MemRead_out  <= MemRead_in;
         MemWrite_out <= MemWrite_in;
      end
   end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter: FWD_EN, default 1, meaning 1 = forwarding muxes active, 0 = operands taken directly from ReadData1_in/ReadData2_in.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ReadData1_in, ReadData2_in, sign_ext_in  input  32 each  ID/EX operand and immediate values.
REQ-006 Fw_rs_in, Fw_rt_in, MUX_rd_in, MUX_rt_in  input  5 each  ID/EX source and destination register numbers.
REQ-007 RegDst_in, ALUSrc_in, MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in  input  1 each  ID/EX control bits.
REQ-008 ALUop_in  input  2  ID/EX ALU operation class.
REQ-009 wb_RegWrite, wb_rd, wb_data  input  1/5/32  MEM/WB write-back port for forwarding.
REQ-010 stall, flush  input  1 each  hold the EX/MEM register; insert a bubble.
REQ-011 ALUResult_out, WriteData_out  output  32 each  registered ALU result; registered forwarded rt value for stores.
REQ-012 WriteReg_out  output  5  registered destination register.
REQ-013 Zero_out, Branch_out, MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out  output  1 each  registered flag and control bits.

Function
REQ-014 Operand A selection: if RegWrite_out=1, WriteReg_out!=0 and WriteReg_out==Fw_rs_in, select ALUResult_out; else if wb_RegWrite=1, wb_rd!=0 and wb_rd==Fw_rs_in, select wb_data; else select ReadData1_in.
REQ-015 The forwarded rt value uses the same rule as REQ-014 with Fw_rt_in and ReadData2_in; an EX/MEM match has priority over a MEM/WB match.
REQ-016 When FWD_EN=0, the operands are ReadData1_in and ReadData2_in unconditionally.
REQ-017 Operand B is sign_ext_in when ALUSrc_in=1; otherwise it is the forwarded rt value.
REQ-018 ALU control:
- ALUop 00: add.
- ALUop 01: sub.
- ALUop 10: decode sign_ext_in[5:0]: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- Any other funct, and ALUop 11: add.
REQ-019 Add and sub are 32-bit modulo 2^32; overflow is ignored and no trap is raised.
REQ-020 slt is a signed compare; its result is 32'd1 or 32'd0.
REQ-021 The Zero flag is 1 exactly when the 32-bit ALU result equals 0.
REQ-022 The destination register is MUX_rd_in when RegDst_in=1; otherwise it is MUX_rt_in.
REQ-023 Latency: inputs presented in cycle N appear on the outputs after the rising edge ending cycle N (one cycle).
REQ-024 Update priority per edge: reset > flush > stall > load.
REQ-025 flush=1: all control outputs (Branch, MemtoReg, RegWrite, MemRead, MemWrite) and Zero_out become 0; the data outputs and WriteReg_out load normally.
REQ-026 stall=1 with flush=0: all outputs hold their values.
REQ-027 Forwarding from the EX/MEM register uses the registered values, including during a stall.

Reset
REQ-028 On a rising edge with reset=1, every output becomes 0: 32'd0 for the 32-bit outputs, 5'd0 for WriteReg_out, 1'b0 for the flag and control bits.
REQ-029 Reset asserted mid-operation discards the in-flight instruction; the cycle after reset deasserts, the block loads its inputs normally.

Verification
REQ-030 Reset: drive all inputs nonzero and assert reset for 1 cycle -> all outputs read 0 on the next cycle.
REQ-031 R-type sub: ReadData1=10, ReadData2=10, ALUop=10, funct=100010, RegDst=1, rd=5 -> ALUResult=0, Zero=1, WriteReg=5.
REQ-032 EX/MEM forwarding:
- Cycle 1: add writes r3 = 7.
- Cycle 2: Fw_rs_in=3, ReadData1=99, ReadData2=1, while wb_rd=3 with wb_data=50.
- Required: ALUResult=8 (EX/MEM has priority over MEM/WB).
REQ-033 MEM/WB forwarding:
- Stimulus: only wb_RegWrite=1, wb_rd=4, wb_data=0x10, Fw_rt_in=4, MemWrite=1.
- Required: WriteData_out=0x10.
- With wb_rd=0 instead: WriteData_out=ReadData2_in.
REQ-034 slt signed: A=0xFFFFFFFF, B=1 -> ALUResult=1; A=1, B=0xFFFFFFFF -> ALUResult=0.
REQ-035 stall held 2 cycles -> outputs unchanged; flush and stall asserted together -> RegWrite_out=0 and MemWrite_out=0 on the next cycle (flush wins).
